// File: rtl/ysyx_bus_pkg.sv
// Shared types and constants for the ysyx bus scheduler: FSM states, owners,
// fixed AXI field values and the requester strobe to AXI size mapping.
package ysyx_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR   = 3'd3,
    ST_WR_B = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OWN_IFU = 2'd0,
    OWN_LD  = 2'd1,
    OWN_ST  = 2'd2
  } owner_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [3:0] AXI_ID_ZERO    = 4'd0;

  // Byte, half and word strobes map to their natural size; anything else is a word.
  function automatic logic [2:0] strb_to_size(input logic [7:0] strb);
    case (strb)
      8'h01:   return 3'd0;
      8'h03:   return 3'd1;
      8'h0f:   return 3'd2;
      default: return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_bus_wlane.sv
// Write lane alignment: shifts the requester word by the byte offset, replicates
// it on both 32-bit halves and places the shifted strobe in the half picked by addr[2].
module ysyx_bus_wlane #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]          addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [3:0]          wstrb,
  output logic [2*DATA_W-1:0] lane_wdata,
  output logic [7:0]          lane_wstrb
);

  logic [DATA_W-1:0] shifted;
  logic [3:0]        strb_sh;

  always_comb begin
    shifted    = wdata << {addr[1:0], 3'b000};
    strb_sh    = wstrb << addr[1:0];
    lane_wdata = {shifted, shifted};
    lane_wstrb = addr[2] ? {strb_sh, 4'b0000} : {4'b0000, strb_sh};
  end

endmodule

// File: rtl/ysyx_bus_sched.sv
// Single-outstanding AXI4 scheduler for IFU read, LSU load and LSU store.
// Optional watchdog under YSYX_BUS_SCHED_TIMEOUT_EN forces an error response after 0xFFFF busy cycles.
module ysyx_bus_sched
  import ysyx_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic [DATA_W-1:0] ifu_rdata_o,
  output logic              ifu_rvalid_o,
  output logic              ifu_rerr_o,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [7:0]        lsu_rstrb,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              lsu_rvalid_o,
  output logic              lsu_rerr_o,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wstrb,
  input  logic              lsu_wvalid,
  output logic              lsu_wready_o,
  output logic              lsu_werr_o,
  output logic [ADDR_W-1:0] io_master_araddr,
  output logic              io_master_arvalid,
  output logic [2:0]        io_master_arsize,
  output logic [7:0]        io_master_arlen,
  output logic [1:0]        io_master_arburst,
  output logic [3:0]        io_master_arid,
  input  logic              io_master_arready,
  input  logic [63:0]       io_master_rdata,
  input  logic [1:0]        io_master_rresp,
  input  logic              io_master_rvalid,
  input  logic              io_master_rlast,
  output logic              io_master_rready,
  output logic [ADDR_W-1:0] io_master_awaddr,
  output logic              io_master_awvalid,
  output logic [2:0]        io_master_awsize,
  output logic [7:0]        io_master_awlen,
  output logic [1:0]        io_master_awburst,
  output logic [3:0]        io_master_awid,
  input  logic              io_master_awready,
  output logic [63:0]       io_master_wdata,
  output logic [7:0]        io_master_wstrb,
  output logic              io_master_wvalid,
  output logic              io_master_wlast,
  input  logic              io_master_wready,
  input  logic [1:0]        io_master_bresp,
  input  logic              io_master_bvalid,
  output logic              io_master_bready,
  output logic [2:0]        dbg_state_o
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d, grant_own;
  logic                grant_vld, any_pulse, aw_fire, w_fire;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                arvalid_q, arvalid_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                rready_q, rready_d, bready_q, bready_d, err_q, err_d;
  logic                ifu_pls_q, ifu_pls_d, ld_pls_q, ld_pls_d, st_pls_q, st_pls_d;
  logic [2*DATA_W-1:0] lane_wdata;
  logic [7:0]          lane_wstrb;
`ifdef YSYX_BUS_SCHED_TIMEOUT_EN
  logic [15:0]         wdog_q, wdog_d;
`endif

  ysyx_bus_wlane #(.DATA_W(DATA_W)) u_wlane (
    .addr       (addr_q[2:0]),
    .wdata      (wdata_q),
    .wstrb      (wstrb_q),
    .lane_wdata (lane_wdata),
    .lane_wstrb (lane_wstrb)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    starve_d  = starve_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    arvalid_d = arvalid_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    rready_d  = rready_q;
    bready_d  = bready_q;
    err_d     = err_q;
    ifu_pls_d = 1'b0;
    ld_pls_d  = 1'b0;
    st_pls_d  = 1'b0;
    grant_vld = 1'b0;
    grant_own = OWN_IFU;
    any_pulse = ifu_pls_q | ld_pls_q | st_pls_q;
    aw_fire   = awvalid_q & io_master_awready;
    w_fire    = wvalid_q & io_master_wready;

    case (state_q)
      ST_IDLE: begin
        // No grant in a response cycle: the requester still holds its valid then.
        if (!any_pulse) begin
          if (ifu_arvalid && starve_q == STARVE_LIM) begin
            grant_vld = 1'b1; grant_own = OWN_IFU;
          end else if (lsu_wvalid) begin
            grant_vld = 1'b1; grant_own = OWN_ST;
          end else if (lsu_arvalid) begin
            grant_vld = 1'b1; grant_own = OWN_LD;
          end else if (ifu_arvalid) begin
            grant_vld = 1'b1; grant_own = OWN_IFU;
          end
        end
        if (grant_vld) begin
          owner_d = grant_own;
          if (grant_own == OWN_IFU) starve_d = '0;
          else if (ifu_arvalid && starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
          case (grant_own)
            OWN_ST: begin
              addr_d    = lsu_awaddr;
              size_d    = strb_to_size(lsu_wstrb);
              wdata_d   = lsu_wdata;
              wstrb_d   = lsu_wstrb[3:0];
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              state_d   = ST_WR;
            end
            OWN_LD: begin
              addr_d    = lsu_araddr;
              size_d    = strb_to_size(lsu_rstrb);
              arvalid_d = 1'b1;
              state_d   = ST_RD_A;
            end
            default: begin
              addr_d    = ifu_araddr;
              size_d    = 3'd2;
              arvalid_d = 1'b1;
              state_d   = ST_RD_A;
            end
          endcase
        end
      end
      ST_RD_A: begin
        if (io_master_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_D;
        end
      end
      ST_RD_D: begin
        if (io_master_rvalid && io_master_rlast) begin
          rready_d  = 1'b0;
          rdata_d   = addr_q[2] ? io_master_rdata[63:32] : io_master_rdata[31:0];
          err_d     = (io_master_rresp != AXI_RESP_OKAY);
          ifu_pls_d = (owner_q == OWN_IFU);
          ld_pls_d  = (owner_q == OWN_LD);
          state_d   = ST_IDLE;
        end
      end
      ST_WR: begin
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        awvalid_d = awvalid_q & ~aw_fire;
        wvalid_d  = wvalid_q & ~w_fire;
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_B;
        end
      end
      ST_WR_B: begin
        if (io_master_bvalid) begin
          bready_d  = 1'b0;
          err_d     = (io_master_bresp != AXI_RESP_OKAY);
          st_pls_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef YSYX_BUS_SCHED_TIMEOUT_EN
    wdog_d = (state_q == ST_IDLE) ? 16'd0 : wdog_q + 16'd1;
    // A hung slave is abandoned and the owner sees an error response.
    if (state_q != ST_IDLE && wdog_q == 16'hFFFF) begin
      state_d   = ST_IDLE;
      arvalid_d = 1'b0;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      rready_d  = 1'b0;
      bready_d  = 1'b0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      err_d     = 1'b1;
      ifu_pls_d = (owner_q == OWN_IFU);
      ld_pls_d  = (owner_q == OWN_LD);
      st_pls_d  = (owner_q == OWN_ST);
      wdog_d    = 16'd0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IFU;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      starve_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rready_q  <= 1'b0;
      bready_q  <= 1'b0;
      err_q     <= 1'b0;
      ifu_pls_q <= 1'b0;
      ld_pls_q  <= 1'b0;
      st_pls_q  <= 1'b0;
`ifdef YSYX_BUS_SCHED_TIMEOUT_EN
      wdog_q    <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      starve_q  <= starve_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      arvalid_q <= arvalid_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      rready_q  <= rready_d;
      bready_q  <= bready_d;
      err_q     <= err_d;
      ifu_pls_q <= ifu_pls_d;
      ld_pls_q  <= ld_pls_d;
      st_pls_q  <= st_pls_d;
`ifdef YSYX_BUS_SCHED_TIMEOUT_EN
      wdog_q    <= wdog_d;
`endif
    end
  end

  assign ifu_rdata_o       = rdata_q;
  assign ifu_rvalid_o      = ifu_pls_q;
  assign ifu_rerr_o        = ifu_pls_q & err_q;
  assign lsu_rdata_o       = rdata_q;
  assign lsu_rvalid_o      = ld_pls_q;
  assign lsu_rerr_o        = ld_pls_q & err_q;
  assign lsu_wready_o      = st_pls_q;
  assign lsu_werr_o        = st_pls_q & err_q;

  assign io_master_araddr  = addr_q;
  assign io_master_arvalid = arvalid_q;
  assign io_master_arsize  = size_q;
  assign io_master_arlen   = AXI_LEN_SINGLE;
  assign io_master_arburst = AXI_BURST_INCR;
  assign io_master_arid    = AXI_ID_ZERO;
  assign io_master_rready  = rready_q;
  assign io_master_awaddr  = addr_q;
  assign io_master_awvalid = awvalid_q;
  assign io_master_awsize  = size_q;
  assign io_master_awlen   = AXI_LEN_SINGLE;
  assign io_master_awburst = AXI_BURST_INCR;
  assign io_master_awid    = AXI_ID_ZERO;
  assign io_master_wdata   = lane_wdata;
  assign io_master_wstrb   = lane_wstrb;
  assign io_master_wvalid  = wvalid_q;
  assign io_master_wlast   = 1'b1;
  assign io_master_bready  = bready_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_ysyx_bus_sched.sv
// Bench for ysyx_bus_sched: directed scenarios plus a randomized mix, with an
// AXI slave driven from tasks and a transaction-level arbitration/lane model.
module tb_ysyx_bus_sched;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] ifu_araddr, lsu_araddr, lsu_awaddr;
  logic              ifu_arvalid, lsu_arvalid, lsu_wvalid;
  logic [7:0]        lsu_rstrb, lsu_wstrb;
  logic [DATA_W-1:0] lsu_wdata, ifu_rdata_o, lsu_rdata_o;
  logic              ifu_rvalid_o, ifu_rerr_o, lsu_rvalid_o, lsu_rerr_o, lsu_wready_o, lsu_werr_o;
  logic [ADDR_W-1:0] io_master_araddr, io_master_awaddr;
  logic              io_master_arvalid, io_master_arready, io_master_awvalid, io_master_awready;
  logic [2:0]        io_master_arsize, io_master_awsize, dbg_state_o;
  logic [7:0]        io_master_arlen, io_master_awlen, io_master_wstrb;
  logic [1:0]        io_master_arburst, io_master_awburst, io_master_rresp, io_master_bresp;
  logic [3:0]        io_master_arid, io_master_awid;
  logic [63:0]       io_master_rdata, io_master_wdata;
  logic              io_master_rvalid, io_master_rlast, io_master_rready;
  logic              io_master_wvalid, io_master_wlast, io_master_wready;
  logic              io_master_bvalid, io_master_bready;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulse_cyc = 0;
  int m_starve = 0;
  int refill_mode = 0;
  logic [DATA_W:0] exp_q[$];

  ysyx_bus_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
    .ifu_rdata_o(ifu_rdata_o), .ifu_rvalid_o(ifu_rvalid_o), .ifu_rerr_o(ifu_rerr_o),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
    .lsu_rdata_o(lsu_rdata_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rerr_o(lsu_rerr_o),
    .lsu_awaddr(lsu_awaddr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
    .lsu_wready_o(lsu_wready_o), .lsu_werr_o(lsu_werr_o),
    .io_master_araddr(io_master_araddr), .io_master_arvalid(io_master_arvalid),
    .io_master_arsize(io_master_arsize), .io_master_arlen(io_master_arlen),
    .io_master_arburst(io_master_arburst), .io_master_arid(io_master_arid),
    .io_master_arready(io_master_arready),
    .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp),
    .io_master_rvalid(io_master_rvalid), .io_master_rlast(io_master_rlast),
    .io_master_rready(io_master_rready),
    .io_master_awaddr(io_master_awaddr), .io_master_awvalid(io_master_awvalid),
    .io_master_awsize(io_master_awsize), .io_master_awlen(io_master_awlen),
    .io_master_awburst(io_master_awburst), .io_master_awid(io_master_awid),
    .io_master_awready(io_master_awready),
    .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
    .io_master_wvalid(io_master_wvalid), .io_master_wlast(io_master_wlast),
    .io_master_wready(io_master_wready),
    .io_master_bresp(io_master_bresp), .io_master_bvalid(io_master_bvalid),
    .io_master_bready(io_master_bready),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic finish_test();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Reference model: arbitration rules, size map and byte-lane placement
  function automatic int pick_owner(input bit ip, input bit lp, input bit sp);
    if (ip && m_starve == STARVE_MAX) return 0;
    if (sp) return 2;
    if (lp) return 1;
    if (ip) return 0;
    return -1;
  endfunction

  function automatic logic [2:0] exp_size(input logic [7:0] strb);
    if (strb == 8'h01) return 3'd0;
    if (strb == 8'h03) return 3'd1;
    return 3'd2;
  endfunction

  function automatic logic [7:0] rand_strb();
    case ($urandom_range(0, 4))
      0: return 8'h01;
      1: return 8'h03;
      2: return 8'h0f;
      3: return 8'($urandom_range(0, 255));
      default: return 8'h0f;
    endcase
  endfunction

  // Driver tasks
  task automatic raise_ifu();
    ifu_araddr = $urandom; ifu_arvalid = 1'b1;
  endtask

  task automatic raise_ld();
    lsu_araddr = $urandom; lsu_rstrb = rand_strb(); lsu_arvalid = 1'b1;
  endtask

  task automatic raise_st();
    lsu_awaddr = $urandom; lsu_wdata = $urandom; lsu_wstrb = rand_strb(); lsu_wvalid = 1'b1;
  endtask

  task automatic refill();
    if (refill_mode == 1 && !lsu_arvalid) raise_ld();
    if (refill_mode == 2) begin
      if (!ifu_arvalid && $urandom_range(0, 1) == 1) raise_ifu();
      if (!lsu_arvalid && $urandom_range(0, 1) == 1) raise_ld();
      if (!lsu_wvalid && $urandom_range(0, 1) == 1) raise_st();
      if (!ifu_arvalid && !lsu_arvalid && !lsu_wvalid) raise_ld();
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ifu_arvalid = 0; lsu_arvalid = 0; lsu_wvalid = 0;
    io_master_arready = 0; io_master_awready = 0; io_master_wready = 0;
    io_master_rvalid = 0; io_master_rlast = 0; io_master_bvalid = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_starve = 0;
    exp_q.delete();
  endtask

  // Called on the negedge where the response pulse is visible.
  task automatic check_pulse(input int own);
    logic [DATA_W:0] e;
    pulse_cyc = cyc;
    check("ifu_pulse", ifu_rvalid_o, own == 0);
    check("ld_pulse", lsu_rvalid_o, own == 1);
    check("st_pulse", lsu_wready_o, own == 2);
    if (own != 2) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      if (own == 0) check("ifu_rdata", {ifu_rerr_o, ifu_rdata_o}, e);
      else          check("ld_rdata", {lsu_rerr_o, lsu_rdata_o}, e);
    end
    if (own == 0) ifu_arvalid = 0;
    if (own == 1) lsu_arvalid = 0;
    if (own == 2) lsu_wvalid = 0;
    refill();
    @(negedge clk);
    check("pulse_once", {ifu_rvalid_o, lsu_rvalid_o, lsu_wready_o}, 0);
    check("turnaround", {io_master_arvalid, io_master_awvalid, io_master_wvalid}, 0);
  endtask

  task automatic serve_read(input int own, input logic [31:0] addr, input logic [2:0] size,
                            input int ar_d, input int r_d, input logic [1:0] resp,
                            input logic [63:0] data);
    check("ar_addr", io_master_araddr, addr);
    check("ar_size", io_master_arsize, size);
    repeat (ar_d) @(negedge clk);
    check("ar_hold", io_master_arvalid, 1);
    io_master_arready = 1; @(negedge clk); io_master_arready = 0;
    check("ar_drop", io_master_arvalid, 0);
    check("rready", io_master_rready, 1);
    repeat (r_d) @(negedge clk);
    exp_q.push_back({resp != 2'b00, addr[2] ? data[63:32] : data[31:0]});
    io_master_rdata = data; io_master_rresp = resp;
    io_master_rvalid = 1; io_master_rlast = 1;
    @(negedge clk);
    io_master_rvalid = 0; io_master_rlast = 0;
    check_pulse(own);
  endtask

  task automatic serve_write(input logic [31:0] addr, input logic [31:0] wd, input logic [7:0] strb,
                             input int aw_d, input int w_d, input int b_d, input logic [1:0] resp);
    logic [31:0] word;
    logic [3:0]  s4;
    int          lane, mx;
    word = '0; s4 = '0;
    for (int i = 0; i < 4; i++) begin
      lane = int'(addr[1:0]) + i;
      if (lane < 4) begin
        word[lane*8 +: 8] = wd[i*8 +: 8];
        if (strb[i]) s4[lane] = 1'b1;
      end
    end
    check("aw_addr", io_master_awaddr, addr);
    check("aw_size", io_master_awsize, exp_size(strb));
    check("w_data", io_master_wdata, {word, word});
    check("w_strb", io_master_wstrb, addr[2] ? {s4, 4'h0} : {4'h0, s4});
    check("w_last", io_master_wlast, 1);
    check("w_valid", io_master_wvalid, 1);
    mx = (aw_d > w_d) ? aw_d : w_d;
    for (int t = 0; t <= mx; t++) begin
      io_master_awready = (t == aw_d);
      io_master_wready  = (t == w_d);
      @(negedge clk);
      if (t == aw_d) check("aw_fire", io_master_awvalid, 0);
      if (t == w_d)  check("w_fire", io_master_wvalid, 0);
    end
    io_master_awready = 0; io_master_wready = 0;
    check("bready", io_master_bready, 1);
    for (int t = 0; t < b_d; t++) begin
      check("no_early_ack", lsu_wready_o, 0);
      @(negedge clk);
    end
    io_master_bresp = resp; io_master_bvalid = 1;
    @(negedge clk);
    io_master_bvalid = 0;
    check("werr", lsu_werr_o, resp != 2'b00);
    check_pulse(2);
  endtask

  // One complete transaction: predict the winner, wait for the bus, play the slave.
  task automatic serve_next(input int ar_d, input int r_d, input int aw_d, input int w_d,
                            input int b_d, input logic [1:0] resp, input logic [63:0] data,
                            output int own);
    bit ip;
    int n;
    ip  = ifu_arvalid;
    own = pick_owner(ifu_arvalid, lsu_arvalid, lsu_wvalid);
    if (ip) m_starve = (own == 0) ? 0 : ((m_starve < STARVE_MAX) ? m_starve + 1 : m_starve);
    n = 0;
    while (!(io_master_arvalid || io_master_awvalid || io_master_wvalid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("bus_wait", 0, 1);
      finish_test();
    end
    check("aw_chan", io_master_awvalid, own == 2);
    check("ar_chan", io_master_arvalid, own != 2);
    if (own == 2) serve_write(lsu_awaddr, lsu_wdata, lsu_wstrb, aw_d, w_d, b_d, resp);
    else if (own == 1) serve_read(1, lsu_araddr, exp_size(lsu_rstrb), ar_d, r_d, resp, data);
    else serve_read(0, ifu_araddr, 3'd2, ar_d, r_d, resp, data);
  endtask

  task automatic serve_rand(output int own);
    logic [1:0] resp;
    resp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
    serve_next($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), resp, {$urandom, $urandom}, own);
  endtask

  task automatic drain();
    int own;
    refill_mode = 0;
    for (int k = 0; k < 5 && (ifu_arvalid || lsu_arvalid || lsu_wvalid); k++) serve_rand(own);
  endtask

  initial begin
    int own, nld, n, t0;
    ifu_araddr = 0; lsu_araddr = 0; lsu_awaddr = 0; lsu_wdata = 0;
    lsu_rstrb = 0; lsu_wstrb = 0; io_master_rdata = 0; io_master_rresp = 0; io_master_bresp = 0;

    // Reset state
    rst = 1'b1;
    ifu_arvalid = 0; lsu_arvalid = 0; lsu_wvalid = 0;
    io_master_arready = 0; io_master_awready = 0; io_master_wready = 0;
    io_master_rvalid = 0; io_master_rlast = 0; io_master_bvalid = 0;
    #1;
    check("rst_valids", {io_master_arvalid, io_master_awvalid, io_master_wvalid}, 0);
    check("rst_readies", {io_master_rready, io_master_bready}, 0);
    check("rst_pulses", {ifu_rvalid_o, lsu_rvalid_o, lsu_wready_o}, 0);
    check("rst_state", dbg_state_o, 0);
    check("ar_consts", {io_master_arlen, io_master_arburst, io_master_arid}, {8'd0, 2'b01, 4'd0});
    check("aw_consts", {io_master_awlen, io_master_awburst, io_master_awid}, {8'd0, 2'b01, 4'd0});
    apply_reset();

    // IFU read, zero-wait slave, 3-cycle latency
    ifu_araddr = 32'h3000_0004; ifu_arvalid = 1; t0 = cyc;
    serve_next(0, 0, 0, 0, 0, 2'b00, 64'h1111_2222_3333_4444, own);
    check("ifu_latency", pulse_cyc - t0, 3);

    // Load and IFU together: load first, then IFU
    lsu_araddr = 32'h8000_0000; lsu_rstrb = 8'h0f; lsu_arvalid = 1;
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1;
    serve_next(0, 1, 0, 0, 0, 2'b00, {$urandom, $urandom}, own);
    check("first_is_ld", own, 1);
    serve_next(1, 0, 0, 0, 0, 2'b00, {$urandom, $urandom}, own);
    check("then_ifu", own, 0);

    // Byte store with W accepted two cycles before AW
    lsu_awaddr = 32'h8000_0006; lsu_wdata = 32'h0000_00ab; lsu_wstrb = 8'h01; lsu_wvalid = 1;
    serve_next(0, 0, 2, 0, 1, 2'b00, 64'd0, own);

    // Store with SLVERR
    raise_st();
    serve_next(0, 0, 1, 1, 0, 2'b10, 64'd0, own);

    // IFU starvation guard under back-to-back loads
    apply_reset();
    refill_mode = 1;
    raise_ifu(); raise_ld();
    nld = 0; own = 1;
    for (int k = 0; k < 20 && own != 0; k++) begin
      serve_rand(own);
      if (own == 1) nld++;
    end
    check("starve_grants", nld, STARVE_MAX);
    drain();

    // Reset while waiting for R: everything drops, no pulse
    ifu_araddr = 32'h3000_0010; ifu_arvalid = 1;
    n = 0;
    while (!io_master_arvalid && n < 50) begin @(negedge clk); n++; end
    check("rst_ar_seen", io_master_arvalid, 1);
    io_master_arready = 1; @(negedge clk); io_master_arready = 0;
    check("rst_in_rd_d", io_master_rready, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rready", io_master_rready, 0);
    check("async_state", dbg_state_o, 0);
    ifu_arvalid = 0;
    io_master_rvalid = 1; io_master_rlast = 1; io_master_rdata = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    rst = 1'b0; m_starve = 0; exp_q.delete();
    io_master_rvalid = 0; io_master_rlast = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_no_pulse", {ifu_rvalid_o, lsu_rvalid_o, lsu_wready_o}, 0);
    end

    // Randomized mix of all three requesters
    refill_mode = 2;
    refill();
    for (int k = 0; k < 60; k++) serve_rand(own);
    drain();

    finish_test();
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    check("global_timeout", 0, 1);
    finish_test();
  end

endmodule
